// File: rtl/mult_div_radix_if.sv
// mult_div_radix_if: request/result handshake bundle for the iterative mul/div unit.
interface mult_div_radix_if #(parameter int DW = 16);
  logic          in_vld;
  logic          in_rdy;
  logic [1:0]    tc_mode;
  logic          operator;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_vld;
  logic          out_rdy;
  logic [2*DW-1:0] c;
  logic          div_by_zero;
  logic          div_overflow;
  modport master (output in_vld, tc_mode, operator, a, b, out_rdy,
                  input  in_rdy, out_vld, c, div_by_zero, div_overflow);
  modport slave  (input  in_vld, tc_mode, operator, a, b, out_rdy,
                  output in_rdy, out_vld, c, div_by_zero, div_overflow);
endinterface

// File: rtl/mult_div_radix.sv
// mult_div_radix: radix-2^BPC iterative MUL/DIV/REM unit, signed/unsigned per operand.
// MULT_DIV_EARLY_OUT_EN enables early-out of trivial cases; MATH_CHECK_OFF disables output checks.
module mult_div_radix #(
  parameter int DW = 16,
  parameter int BPC = 2,
  localparam int C_DW = 2*DW
) (
  input logic clk_i,
  input logic rst_i,
  mult_div_radix_if.slave bus
);
  localparam int N = DW/BPC;
  localparam int CW = $clog2(N+1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic op, a_neg, b_neg, dbz, ovf;
  logic [DW-1:0] a_mag, b_mag, a_in_mag, b_in_mag, quot, rem, a_orig;
  logic [C_DW-1:0] acc, acc_nxt, fixed, e_res;
  logic [DW+BPC-1:0] sum;
  logic [DW:0] r;
  logic [DW-1:0] q;
  logic a_in_neg, b_in_neg, accept, last, in_dbz, in_ovf, early;
  assign bus.in_rdy = state == IDLE;
  assign bus.out_vld = state == DONE;
  assign accept = bus.in_vld & bus.in_rdy;
  assign last = cnt == CW'(N-1);
  assign a_in_neg = bus.tc_mode[0] & bus.a[DW-1];
  assign b_in_neg = bus.tc_mode[1] & bus.b[DW-1];
  assign a_in_mag = a_in_neg ? -bus.a : bus.a;
  assign b_in_mag = b_in_neg ? -bus.b : bus.b;
  assign in_dbz = bus.operator & ~|bus.b;
  assign in_ovf = bus.operator & (&bus.tc_mode) & (bus.a == {1'b1, {(DW-1){1'b0}}}) & (&bus.b);
`ifdef MULT_DIV_EARLY_OUT_EN
  assign early = in_dbz | in_ovf | (~bus.operator & (~|bus.a | ~|bus.b));
`else
  assign early = 1'b0;
`endif
  assign e_res = in_dbz ? {bus.a, {DW{1'b1}}} : in_ovf ? {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}} : '0;
  always_comb begin
    state_nxt = state == IDLE ? (accept ? (early ? DONE : CALC) : IDLE)
              : state == CALC ? (last ? FIX : CALC)
              : state == FIX  ? DONE
              : (bus.out_rdy ? IDLE : DONE);
  end
  // acc holds {hi, lo}: MULT {partial product, remaining multiplier}; DIV {rem, quot}
  always_comb begin
    sum = {{BPC{1'b0}}, acc[C_DW-1:DW]} + (DW+BPC)'(acc[BPC-1:0]) * (DW+BPC)'(b_mag);
    r = {1'b0, acc[C_DW-1:DW]};
    q = acc[DW-1:0];
    for (int i = 0; i < BPC; i++) begin
      r = {r[DW-1:0], q[DW-1]};
      q = {q[DW-2:0], 1'b0};
      if (r >= {1'b0, b_mag}) begin
        r = r - {1'b0, b_mag};
        q[0] = 1'b1;
      end
    end
    acc_nxt = op ? {r[DW-1:0], q} : {sum, acc[DW-1:BPC]};
  end
  assign quot = acc[DW-1:0];
  assign rem = acc[C_DW-1:DW];
  assign a_orig = a_neg ? -a_mag : a_mag;
  assign fixed = ~op ? ((a_neg ^ b_neg) ? -acc : acc)
               : dbz ? {a_orig, {DW{1'b1}}}
               : {a_neg ? -rem : rem, (a_neg ^ b_neg) ? -quot : quot};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      op <= 1'b0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      dbz <= 1'b0;
      ovf <= 1'b0;
      a_mag <= '0;
      b_mag <= '0;
      acc <= '0;
      bus.c <= '0;
      bus.div_by_zero <= 1'b0;
      bus.div_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state == CALC && !last) ? cnt + 1'b1 : '0;
      if (accept) begin
        op <= bus.operator;
        a_neg <= a_in_neg;
        b_neg <= b_in_neg;
        dbz <= in_dbz;
        ovf <= in_ovf;
        a_mag <= a_in_mag;
        b_mag <= b_in_mag;
        acc <= {{DW{1'b0}}, a_in_mag};
      end else if (state == CALC) begin
        acc <= acc_nxt;
      end
      if (accept && early) begin
        bus.c <= e_res;
        bus.div_by_zero <= in_dbz;
        bus.div_overflow <= in_ovf;
      end else if (state == FIX) begin
        bus.c <= fixed;
        bus.div_by_zero <= dbz;
        bus.div_overflow <= ovf;
      end
    end
  end
`ifndef MATH_CHECK_OFF
  assert property (@(posedge clk_i) disable iff (rst_i)
    bus.out_vld && !bus.out_rdy |=> bus.out_vld && $stable(bus.c))
    else $error("result withdrawn or changed while stalled");
`endif
endmodule

// File: tb/tb_mult_div_radix.sv
// tb_mult_div_radix: directed vector table plus stall and mid-operation reset sequences.
module tb_mult_div_radix;
`ifdef MULT_DIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 6;
`endif
  typedef struct {
    logic op;
    logic [1:0] tc;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] c;
    logic dbz;
    logic ovf;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  vec_t vecs[12];
  mult_div_radix_if #(.DW(8)) bus();
  mult_div_radix #(.DW(8), .BPC(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic start(input logic op, input logic [1:0] tc, input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    @(negedge clk);
    while (!bus.in_rdy && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.in_vld = 1'b1;
    bus.operator = op;
    bus.tc_mode = tc;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    bus.operator = 1'($urandom);
    bus.tc_mode = 2'($urandom);
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_vld && lat < 40);
  endtask
  task automatic run_vec(input int k, input vec_t v);
    int lat;
    string tag;
    tag = $sformatf("v%0d", k);
    start(v.op, v.tc, v.a, v.b);
    wait_out(lat);
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_c"}, bus.c, v.c);
    chk({tag, "_dbz"}, bus.div_by_zero, v.dbz);
    chk({tag, "_ovf"}, bus.div_overflow, v.ovf);
    @(negedge clk);
    chk({tag, "_vld_drop"}, bus.out_vld, 0);
  endtask
  initial begin
    int lat;
    vecs[0]  = '{1'b0, 2'b00, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 6};
    vecs[1]  = '{1'b1, 2'b11, 8'hF9, 8'h02, 16'hFFFD, 1'b0, 1'b0, 6};
    vecs[2]  = '{1'b1, 2'b00, 8'h64, 8'h00, 16'h64FF, 1'b1, 1'b0, EL};
    vecs[3]  = '{1'b1, 2'b11, 8'h80, 8'hFF, 16'h0080, 1'b0, 1'b1, EL};
    vecs[4]  = '{1'b0, 2'b11, 8'h80, 8'hFF, 16'h0080, 1'b0, 1'b0, 6};
    vecs[5]  = '{1'b0, 2'b01, 8'hFF, 8'h02, 16'hFFFE, 1'b0, 1'b0, 6};
    vecs[6]  = '{1'b1, 2'b00, 8'hC8, 8'h07, 16'h041C, 1'b0, 1'b0, 6};
    vecs[7]  = '{1'b0, 2'b00, 8'h00, 8'h55, 16'h0000, 1'b0, 1'b0, EL};
    vecs[8]  = '{1'b1, 2'b11, 8'h07, 8'hFE, 16'h01FD, 1'b0, 1'b0, 6};
    vecs[9]  = '{1'b1, 2'b11, 8'hF8, 8'h00, 16'hF8FF, 1'b1, 1'b0, EL};
    vecs[10] = '{1'b0, 2'b11, 8'h7F, 8'h80, 16'hC080, 1'b0, 1'b0, 6};
    vecs[11] = '{1'b1, 2'b00, 8'h80, 8'hFF, 16'h8000, 1'b0, 1'b0, 6};
    bus.in_vld = 1'b0;
    bus.operator = 1'b0;
    bus.tc_mode = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_flags", {bus.div_by_zero, bus.div_overflow}, 0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);
    bus.out_rdy = 1'b0;
    start(1'b0, 2'b00, 8'h03, 8'h05);
    wait_out(lat);
    chk("stall_lat", lat, 6);
    bus.in_vld = 1'b1;
    bus.a = 8'h11;
    bus.b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_vld", bus.out_vld, 1);
      chk("stall_c", bus.c, 16'h000F);
      chk("stall_in_rdy", bus.in_rdy, 0);
    end
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("stall_release_vld", bus.out_vld, 0);
    chk("stall_release_rdy", bus.in_rdy, 1);
    start(1'b1, 2'b00, 8'hC8, 8'h07);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_rdy", bus.in_rdy, 1);
    chk("abort_out_vld", bus.out_vld, 0);
    chk("abort_c", bus.c, 0);
    rst = 1'b0;
    run_vec(100, vecs[1]);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
